// File: rtl/sdac_sequencer.sv
// Serial DAC frame sequencer: buffers one sample, serialises it MSB-first on each rate tick.
// Latency: first SI bit one cycle after the tick; frames repeat every DIV cycles while run is high.
// Backpressure: sample_ready = !full; an empty buffer at a tick resends the last sample and pulses underrun.
module sdac_sequencer #(
  parameter int WIDTH = 12,
  parameter int DIV   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             SI,
  output logic             soc,
  output logic             en,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = $clog2(DIV);
  localparam int KW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(DIV - 1);
  localparam logic [KW-1:0]    K_TOP    = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [KW-1:0]    k_q, k_d;
  logic             si_q, si_d;
  logic             soc_q, soc_d;
  logic             en_q, en_d;
  logic             underrun_q, underrun_d;

  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] src;

  // Next-state logic: period counter, holding buffer and frame serialiser.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    full_d     = full_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    k_d        = k_q;
    si_d       = 1'b0;
    soc_d      = 1'b0;
    en_d       = 1'b0;
    underrun_d = 1'b0;
    src        = last_q;

    accept = sample_valid && !full_q;
    tick   = run && (cnt_q == CNT_MAX);

    if (!run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // accept requires an empty buffer, so it never collides with a consuming tick
    if (accept) begin
      hold_d = sample_in;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (full_q) begin
            src    = hold_q;
            last_d = hold_q;
            full_d = 1'b0;
          end else begin
            src        = last_q;
            underrun_d = 1'b1;
          end
          // MSB goes straight to the output register; shreg keeps the remaining bits
          shreg_d = src << 1;
          si_d    = src[WIDTH-1];
          soc_d   = 1'b1;
          en_d    = 1'b1;
          k_d     = K_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // k_q is the index of the bit currently on SI
        if (k_q == '0) begin
          state_d = IDLE;
        end else begin
          si_d    = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          k_d     = k_q - KW'(1);
          en_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      last_q     <= MIDSCALE;
      k_q        <= '0;
      si_q       <= 1'b0;
      soc_q      <= 1'b0;
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      k_q        <= k_d;
      si_q       <= si_d;
      soc_q      <= soc_d;
      en_q       <= en_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready = !full_q;
  assign SI           = si_q;
  assign soc          = soc_q;
  assign en           = en_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_sdac_sequencer.sv
// Bench for sdac_sequencer: frames are predicted per scenario and queued, then checked as the DUT emits them.
// Latency: first soc expected DIV cycles after run rises or reset releases.
// Backpressure: the sample feeder holds valid until ready was high at an edge.
module tb_sdac_sequencer;

  localparam int W = 12;
  localparam int D = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         run;
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         sample_ready;
  logic         SI, soc, en, busy, underrun;

  sdac_sequencer #(.WIDTH(W), .DIV(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .SI           (SI),
    .soc          (soc),
    .en           (en),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard of expected frames: {underrun, data}
  logic [W:0] exp_q[$];
  int         soc_t[$];
  int         soc_cnt = 0;

  task automatic push_exp(input logic u, input logic [W-1:0] d);
    exp_q.push_back({u, d});
  endtask

  // frame monitor, sampling on the falling edge
  bit           mon_act = 0;
  int           mon_n = 0;
  logic [W-1:0] mon_bits;
  logic [W:0]   mon_exp;
  logic         prev_rdy = 1'b1;
  logic         rdy_at_soc = 1'b0;
  logic         rdy_before_soc = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 0;
    end else if (mon_act) begin
      if (mon_n < W) begin
        chk("frame_ctl", {en, busy, soc, underrun}, 4'b1100);
        mon_bits = {mon_bits[W-2:0], SI};
        mon_n++;
      end else begin
        chk("frame_end", {en, busy, SI}, 3'b000);
        chk("frame_data", mon_bits, mon_exp[W-1:0]);
        mon_act = 0;
      end
    end else if (soc) begin
      soc_cnt++;
      soc_t.push_back(cyc);
      rdy_at_soc     = sample_ready;
      rdy_before_soc = prev_rdy;
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk("frame_start", {en, busy, underrun}, {2'b11, mon_exp[W]});
        mon_bits = {{(W-1){1'b0}}, SI};
        mon_n    = 1;
        mon_act  = 1;
      end
    end
    prev_rdy = sample_ready;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_socs(input int target);
    int guard = 0;
    while (soc_cnt < target && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("soc_wait", soc_cnt >= target, 1);
  endtask

  task automatic feed(input logic [W-1:0] v);
    logic was_rdy;
    bit   done = 0;
    was_rdy      = 1'b0;
    sample_in    = v;
    sample_valid = 1'b1;
    for (int g = 0; g < 300 && !done; g++) begin
      was_rdy = sample_ready;
      @(posedge clk);
      #1;
      if (was_rdy) done = 1;
    end
    chk("feed_accept", done, 1);
  endtask

  int run_cyc;
  int base;
  int saved;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; sample_in = '0; sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {SI, soc, en, busy, underrun, sample_ready}, 6'b000001);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(3);

    // 1: no samples -> midscale with underrun, every D cycles
    base = soc_cnt;
    push_exp(1'b1, 12'h800);
    push_exp(1'b1, 12'h800);
    run = 1'b1; run_cyc = cyc;
    wait_socs(base + 2);
    run = 1'b0;
    chk("first_soc_dly", soc_t[base] - run_cyc, D);
    chk("soc_spacing1", soc_t[base+1] - soc_t[base], D);
    idle(20);

    // 2: single sample offered before the first tick
    sample_in = 12'hA5C; sample_valid = 1'b1;
    idle(1);
    sample_valid = 1'b0;
    chk("ready_after_accept", sample_ready, 0);
    base = soc_cnt;
    push_exp(1'b0, 12'hA5C);
    run = 1'b1; run_cyc = cyc;
    wait_socs(base + 1);
    run = 1'b0;
    chk("soc_dly2", soc_t[base] - run_cyc, D);
    chk("rdy_before_tick", rdy_before_soc, 0);
    chk("rdy_after_tick", rdy_at_soc, 1);
    idle(20);

    // 3: streamed samples with valid held high
    base = soc_cnt;
    push_exp(1'b0, 12'h001);
    push_exp(1'b0, 12'hFFF);
    push_exp(1'b0, 12'h5A5);
    fork
      begin
        feed(12'h001);
        feed(12'hFFF);
        feed(12'h5A5);
        sample_valid = 1'b0;
      end
      begin
        run = 1'b1;
        wait_socs(base + 3);
        run = 1'b0;
      end
    join
    chk("soc_spacing3a", soc_t[base+1] - soc_t[base], D);
    chk("soc_spacing3b", soc_t[base+2] - soc_t[base+1], D);
    idle(20);

    // 4: sample first valid in the tick cycle -> resend previous, new one next frame
    base = soc_cnt;
    push_exp(1'b1, 12'h5A5);
    push_exp(1'b0, 12'h3C3);
    run = 1'b1; run_cyc = cyc;
    idle(D - 1);
    sample_in = 12'h3C3; sample_valid = 1'b1;
    idle(1);
    sample_valid = 1'b0;
    wait_socs(base + 2);
    run = 1'b0;
    chk("soc_dly4", soc_t[base] - run_cyc, D);
    idle(20);

    // 5: drop run mid-frame; frame completes, no further soc until run returns
    sample_in = 12'h6B2; sample_valid = 1'b1;
    idle(1);
    sample_valid = 1'b0;
    base = soc_cnt;
    push_exp(1'b0, 12'h6B2);
    run = 1'b1;
    wait_socs(base + 1);
    idle(5);
    chk("en_before_stop", en, 1);
    run = 1'b0;
    saved = soc_cnt;
    idle(250);
    chk("no_soc_when_stopped", soc_cnt, saved);
    push_exp(1'b1, 12'h6B2);
    run = 1'b1; run_cyc = cyc;
    wait_socs(base + 2);
    run = 1'b0;
    chk("soc_dly5", soc_t[base+1] - run_cyc, D);
    idle(20);

    // 6: reset mid-frame aborts and discards the buffered sample
    sample_in = 12'h123; sample_valid = 1'b1;
    idle(1);
    sample_valid = 1'b0;
    base = soc_cnt;
    push_exp(1'b0, 12'h123);
    run = 1'b1;
    wait_socs(base + 1);
    sample_in = 12'h456; sample_valid = 1'b1;
    idle(1);
    sample_valid = 1'b0;
    chk("rdy_full_mid_frame", sample_ready, 0);
    chk("en_mid_frame", en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {SI, soc, en, busy, underrun, sample_ready}, 6'b000001);
    idle(2);
    rst_n = 1'b1; run_cyc = cyc;
    push_exp(1'b1, 12'h800);
    wait_socs(base + 2);
    run = 1'b0;
    chk("soc_dly6", soc_t[base+1] - run_cyc, D);
    idle(20);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdac_sequencer.md
# sdac_sequencer

Frame sequencer for the serial DAC in the sine-wave path. Accepts parallel samples from the waveform source over a valid/ready handshake and buffers one sample. On a programmable sample-rate tick it serialises the sample MSB-first onto the DAC's `SI` line, generating the DAC's `soc` and `en` strobes. It sits between the sample generator (NCO/LUT) and `SDAC`, runs in the 100 MHz `clk` domain, and guarantees a fixed output sample rate independent of the source.

## Interface
- `WIDTH`, default 12: DAC sample width in bits, legal range 2..16.
- `DIV`, default 100: sample period in `clk` cycles; legal when `DIV >= WIDTH+2`.
- `clk`  in  1  system clock, 100 MHz, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `run`  in  1  enable; when high, the period counter runs and frames are issued.
- `sample_in`  in  WIDTH  unsigned sample from the source.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  the holding buffer is empty; a sample is accepted when valid and ready are both high at a rising edge.
- `SI`  out  1  serial data to the DAC, MSB first.
- `soc`  out  1  start-of-conversion strobe to the DAC, one cycle per frame.
- `en`  out  1  DAC shift enable, high for the WIDTH data cycles.
- `busy`  out  1  a frame is in progress.
- `underrun`  out  1  one-cycle pulse when a tick finds the buffer empty.

## Operation
- Storage:
  - Holding buffer `hold` (WIDTH bits) plus a `full` flag.
  - Shift register `shreg` (WIDTH bits).
  - `last` register holding the last sample sent; reset value is midscale, `1 << (WIDTH-1)`.
- `sample_ready = !full` (combinational from the registered flag). An accept sets `full` and loads `hold`.
- Period counter `cnt`, range 0..DIV-1:
  - Counts only while `run` is high. `tick` is asserted when `cnt == DIV-1`, and `cnt` then wraps to 0.
  - When `run` is low, `cnt` is held at 0.
- States:
  - IDLE: waits for `tick`. On `tick`:
    - If `full`: `shreg <= hold`, `last <= hold`, clear `full`.
    - Otherwise: `shreg <= last` and pulse `underrun`.
    - In both cases go to SHIFT with bit index `k = WIDTH-1`.
  - SHIFT: `SI = shreg[k]`, `en = 1`, `soc = 1` only when `k == WIDTH-1`. `k` decrements each cycle. After `k == 0`, return to IDLE.
- `busy = (state == SHIFT)`.
- Simultaneous events:
  - Accept in the same cycle as `tick` while `full == 0`: the tick sees the buffer as empty, so `underrun` pulses and `last` is resent. The new sample lands in `hold` and is used at the next tick. There is no bypass.
  - `tick` with `full == 1` and `sample_valid == 1`: `sample_ready` is 0 that cycle, so nothing is accepted. Ready rises the next cycle.
  - Accepting a sample during SHIFT is legal. It fills `hold` and does not disturb the current frame.
- When `run` falls mid-frame, the current frame completes, then the block stays in IDLE. The buffer contents are retained.
- Reset, including mid-frame, forces an immediate abort:
  - `state = IDLE`, `cnt = 0`, `full = 0`, `last = midscale`.
  - All outputs go to 0 except `sample_ready = 1`.

## Timing
- Outputs `SI`, `soc`, `en` and `underrun` are registered. `busy` is decoded from the registered state.
- Let T be the edge where `cnt == DIV-1` is sampled (the tick).
  - Cycle T+1: `soc = 1`, `en = 1`, `SI = MSB`.
  - Cycles T+1 .. T+WIDTH: `en = 1`, `SI` carries bit WIDTH-1 down to bit 0, one bit per cycle.
  - Cycle T+WIDTH+1: `en = 0`, `SI = 0`.
  - `underrun`, when it occurs, is high in cycle T+1 only.
- Frame spacing is exactly DIV cycles from `soc` to `soc` while `run` is held high.
- The first tick after `run` rises (or after reset release with `run` high) is DIV cycles later.
- `sample_ready` rises in cycle T+1 after a tick that consumed the buffer.
- Data changes on the rising edge. The DAC samples `SI` on the following rising edge while `en = 1`.

## Test plan
Every scenario uses `WIDTH=12`, `DIV=100`, 100 MHz `clk`.
- Reset, then `run=1`, no samples offered: the first `soc` occurs 100 cycles after `run` rises. `SI` carries 0x800 (1 followed by 11 zeros) and `underrun` pulses with `soc`. This repeats every 100 cycles.
- Offer 0xA5C before the first tick: `soc` fires. `SI` over 12 cycles is 1010 0101 1100 with `en` high for exactly 12 cycles. `sample_ready` returns to 1 one cycle after the tick.
- Stream 0x001, 0xFFF, 0x5A5 with `sample_valid` held high: each value is accepted one tick ahead. Frames carry the values in order, spaced 100 cycles apart, with no underrun.
- Present a sample first valid exactly at the tick cycle while the buffer is empty: that frame resends the previous value and `underrun` pulses. The new sample is sent on the next frame.
- Drop `run` at bit 5 of a frame: the frame completes all 12 bits, then no further `soc` appears. Raising `run` again gives the next `soc` 100 cycles later.
- Assert `rst_n=0` mid-frame: `SI`, `soc`, `en`, `busy` and `underrun` go to 0 immediately, `sample_ready` goes to 1, and the buffered sample is discarded. The next frame after release sends 0x800 with `underrun`.
